processador_acumulador: RTL

- Parametrised multi-cycle accumulator processor core. Successor to the fixed 8-bit ULA/MUX/control-unit/RAM processor.
- Fetches `(4+ADDR_WIDTH)`-bit instructions and executes them through one FSM.
- Instructions and data share one external memory, accessed over a req/ready handshake that tolerates wait states.
- Adds flags, conditional jumps, halt and single-step, and exposes its architectural state for LED/HEX debug.

---
 rtl/processador_acumulador.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/processador_acumulador.sv
// Multi-cycle accumulator processor core: one FSM fetches and executes
// (4+ADDR_WIDTH)-bit instructions from a shared req/ready memory.
module processador_acumulador #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    run,
  input  logic                    step,
  output logic                    mem_req,
  output logic                    mem_we,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  input  logic [DATA_WIDTH-1:0]   mem_rdata,
  input  logic                    mem_ready,
  output logic [DATA_WIDTH-1:0]   acc_out,
  output logic [ADDR_WIDTH-1:0]   pc_out,
  output logic [4+ADDR_WIDTH-1:0] ir_out,
  output logic [1:0]              flags_out,
  output logic                    halted
);

  localparam int IW = 4 + ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ONE = ADDR_WIDTH'(1);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_LDI = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_XOR = 4'h8;
  localparam logic [3:0] OP_NOT = 4'h9;
  localparam logic [3:0] OP_SHL = 4'hA;
  localparam logic [3:0] OP_SHR = 4'hB;
  localparam logic [3:0] OP_JMP = 4'hC;
  localparam logic [3:0] OP_JZ  = 4'hD;
  localparam logic [3:0] OP_JC  = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_MEM_RD,
    S_MEM_WR,
    S_HALT
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_pc, w_pc_nxt;
  logic [DATA_WIDTH-1:0] r_acc, w_acc_nxt;
  logic [IW-1:0]         r_ir, w_ir_nxt;
  logic                  r_c, w_c_nxt;
  logic                  r_z, w_z_nxt;
  logic                  r_step_d;
  logic                  r_step_pending, w_step_pending_nxt;
  logic                  r_fetch_busy, w_fetch_busy_nxt;

  logic                  w_acc_wr;
  logic                  w_xfer;
  logic                  w_fetch_go;
  logic                  w_step_edge;
  logic [3:0]            w_opcode;
  logic [ADDR_WIDTH-1:0] w_operand;
  logic [DATA_WIDTH:0]   w_sum;
  logic [DATA_WIDTH-1:0] w_diff;
  logic [DATA_WIDTH-1:0] w_imm;
  logic                  w_borrow;

  assign w_opcode    = r_ir[IW-1:ADDR_WIDTH];
  assign w_operand   = r_ir[ADDR_WIDTH-1:0];
  assign w_sum       = {1'b0, r_acc} + {1'b0, mem_rdata};
  assign w_diff      = r_acc - mem_rdata;
  assign w_borrow    = (r_acc < mem_rdata);
  assign w_imm       = {{(DATA_WIDTH-ADDR_WIDTH){1'b0}}, w_operand};
  assign w_step_edge = step & ~r_step_d;
  // A fetch already on the bus stays requested even if run/step go away.
  assign w_fetch_go  = run | r_step_pending | r_fetch_busy;
  assign w_xfer      = mem_req & mem_ready;

  always_comb begin
    mem_req  = 1'b0;
    mem_we   = 1'b0;
    mem_addr = r_pc;
    case (r_state)
      S_FETCH:  mem_req = w_fetch_go;
      S_MEM_RD: begin
        mem_req  = 1'b1;
        mem_addr = w_operand;
      end
      S_MEM_WR: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = w_operand;
      end
      default: ;
    endcase
    // Reset drops a pending request combinationally, without waiting for a clock.
    if (!reset_n) begin
      mem_req = 1'b0;
      mem_we  = 1'b0;
    end
  end

  always_comb begin
    w_step_pending_nxt = r_step_pending | w_step_edge;
    if ((r_state == S_FETCH) && w_xfer)
      w_step_pending_nxt = 1'b0;
    w_fetch_busy_nxt = (r_state == S_FETCH) & mem_req & ~mem_ready;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_acc_nxt   = r_acc;
    w_ir_nxt    = r_ir;
    w_c_nxt     = r_c;
    w_z_nxt     = r_z;
    w_acc_wr    = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (w_xfer) begin
          w_ir_nxt    = mem_rdata[IW-1:0];
          w_pc_nxt    = r_pc + PC_ONE;
          w_state_nxt = S_DECODE;
        end
      end
      S_DECODE: begin
        w_state_nxt = S_FETCH;
        case (w_opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR: w_state_nxt = S_MEM_RD;
          OP_STA: w_state_nxt = S_MEM_WR;
          OP_LDI: begin
            w_acc_nxt = w_imm;
            w_acc_wr  = 1'b1;
          end
          OP_NOT: begin
            w_acc_nxt = ~r_acc;
            w_acc_wr  = 1'b1;
          end
          OP_SHL: begin
            w_acc_nxt = {r_acc[DATA_WIDTH-2:0], 1'b0};
            w_c_nxt   = r_acc[DATA_WIDTH-1];
            w_acc_wr  = 1'b1;
          end
          OP_SHR: begin
            w_acc_nxt = {1'b0, r_acc[DATA_WIDTH-1:1]};
            w_c_nxt   = r_acc[0];
            w_acc_wr  = 1'b1;
          end
          OP_JMP: w_pc_nxt = w_operand;
          OP_JZ:  if (r_z) w_pc_nxt = w_operand;
          OP_JC:  if (r_c) w_pc_nxt = w_operand;
          OP_HLT: w_state_nxt = S_HALT;
          OP_NOP: ;
          default: ;
        endcase
      end
      S_MEM_RD: begin
        if (w_xfer) begin
          w_state_nxt = S_FETCH;
          w_acc_wr    = 1'b1;
          case (w_opcode)
            OP_LDA: w_acc_nxt = mem_rdata;
            OP_ADD: {w_c_nxt, w_acc_nxt} = w_sum;
            OP_SUB: begin
              w_acc_nxt = w_diff;
              w_c_nxt   = w_borrow;
            end
            OP_AND: w_acc_nxt = r_acc & mem_rdata;
            OP_OR:  w_acc_nxt = r_acc | mem_rdata;
            OP_XOR: w_acc_nxt = r_acc ^ mem_rdata;
            default: w_acc_wr = 1'b0;
          endcase
        end
      end
      S_MEM_WR: begin
        if (w_xfer)
          w_state_nxt = S_FETCH;
      end
      S_HALT: w_state_nxt = S_HALT;
      default: w_state_nxt = S_FETCH;
    endcase
    if (w_acc_wr)
      w_z_nxt = (w_acc_nxt == '0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= S_FETCH;
      r_pc           <= '0;
      r_acc          <= '0;
      r_ir           <= '0;
      r_c            <= 1'b0;
      r_z            <= 1'b0;
      r_step_d       <= 1'b0;
      r_step_pending <= 1'b0;
      r_fetch_busy   <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_pc           <= w_pc_nxt;
      r_acc          <= w_acc_nxt;
      r_ir           <= w_ir_nxt;
      r_c            <= w_c_nxt;
      r_z            <= w_z_nxt;
      r_step_d       <= step;
      r_step_pending <= w_step_pending_nxt;
      r_fetch_busy   <= w_fetch_busy_nxt;
    end
  end

  assign mem_wdata = r_acc;
  assign acc_out   = r_acc;
  assign pc_out    = r_pc;
  assign ir_out    = r_ir;
  assign flags_out = {r_c, r_z};
  assign halted    = (r_state == S_HALT);

endmodule
